// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronises and filters the line clock,
// then deserialises 11-bit frames into bytes with valid/error strobes.
module ps2_receiver #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 6000
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_data_clk,
  output logic       ps2_err
);

  localparam int FCW = $clog2(FILTER + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic           clk_s1;
  logic           clk_s2;
  logic           dat_s1;
  logic           dat_s2;
  logic           clk_f;
  logic           clk_f_q;
  logic [FCW-1:0] fcnt;
  logic           fall;

  state_t         state;
  logic [2:0]     bitcnt;
  logic [TCW-1:0] tcnt;
  logic [7:0]     shreg;
  logic           par;

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // clk_f only follows a level that has been stable for FILTER cycles
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      clk_f   <= 1'b1;
      clk_f_q <= 1'b1;
      fcnt    <= '0;
    end else begin
      clk_f_q <= clk_f;
      if (clk_s2 != clk_f) begin
        if (fcnt == FCW'(FILTER - 1)) begin
          clk_f <= clk_s2;
          fcnt  <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign fall = clk_f_q & ~clk_f;

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bitcnt       <= '0;
      tcnt         <= '0;
      shreg        <= '0;
      par          <= 1'b0;
      ps2_data     <= 8'h00;
      ps2_data_clk <= 1'b0;
      ps2_err      <= 1'b0;
    end else begin
      ps2_data_clk <= 1'b0;
      ps2_err      <= 1'b0;
      if (state == IDLE) begin
        tcnt   <= '0;
        bitcnt <= '0;
        if (fall && !dat_s2) begin
          state <= DATA;
        end
      end else if (fall) begin
        tcnt <= '0;
        unique case (state)
          DATA: begin
            shreg <= {dat_s2, shreg[7:1]};
            if (bitcnt == 3'd7) begin
              bitcnt <= '0;
              state  <= PARITY;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2 && ((^shreg) ^ par)) begin
              ps2_data     <= shreg;
              ps2_data_clk <= 1'b1;
            end else begin
              ps2_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (tcnt == TCW'(TIMEOUT)) begin
        // stalled partial frame: drop it and report
        state   <= IDLE;
        bitcnt  <= '0;
        tcnt    <= '0;
        ps2_err <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: drives PS/2 frames, compares strobes and
// bytes against a frame-level reference model.
module tb_ps2_receiver;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 6000;
  localparam int HALF    = 40;

  logic       clock50;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] ps2_data;
  logic       ps2_data_clk;
  logic       ps2_err;

  int vectors;
  int miscompares;
  int cyc;
  int last_fall_cyc;
  int last_err_cyc;
  int err_cnt;
  int overlap_cnt;
  logic [7:0] got_q[$];

  ps2_receiver #(
    .FILTER(FILTER),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock50(clock50),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .ps2_data(ps2_data),
    .ps2_data_clk(ps2_data_clk),
    .ps2_err(ps2_err)
  );

  initial clock50 = 1'b0;
  always #10 clock50 = ~clock50;

  always @(posedge clock50) cyc++;

  always @(negedge clock50) begin
    if (ps2_data_clk) got_q.push_back(ps2_data);
    if (ps2_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (ps2_data_clk && ps2_err) overlap_cnt++;
  end

  // parity bit that makes the 9-bit total odd, from a plain ones count
  function automatic logic odd_bit(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    return (ones % 2 == 0);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock50);
  endtask

  task automatic clear_mon();
    got_q.delete();
    err_cnt     = 0;
    overlap_cnt = 0;
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    @(negedge clock50);
    ps2_dat = b;
    if (glitch) begin
      idle(15);
      ps2_clk = 1'b0;
      idle(3);
      ps2_clk = 1'b1;
      idle(HALF - 18);
    end else begin
      idle(HALF);
    end
    ps2_clk       = 1'b0;
    last_fall_cyc = cyc;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p,
                            input logic stop, input logic glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(p, glitch);
    send_bit(stop, glitch);
  endtask

  task automatic expect_frames(input string name, input int n,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input int errs);
    idle(2 * FILTER + 10);
    vectors++;
    if (got_q.size() != n) begin
      miscompares++;
      $display("FAIL %s strobes: got %0d want %0d", name, got_q.size(), n);
    end else begin
      if (n > 0) begin
        vectors++;
        if (got_q[0] !== b0) begin
          miscompares++;
          $display("FAIL %s byte0: got %h want %h", name, got_q[0], b0);
        end
      end
      if (n > 1) begin
        vectors++;
        if (got_q[1] !== b1) begin
          miscompares++;
          $display("FAIL %s byte1: got %h want %h", name, got_q[1], b1);
        end
      end
    end
    vectors++;
    if (err_cnt != errs) begin
      miscompares++;
      $display("FAIL %s errs: got %0d want %0d", name, err_cnt, errs);
    end
  endtask

  task automatic check_data(input string name, input logic [7:0] exp);
    vectors++;
    if (ps2_data !== exp) begin
      miscompares++;
      $display("FAIL %s ps2_data: got %h want %h", name, ps2_data, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(4);
    vectors++;
    if ({ps2_data, ps2_data_clk, ps2_err} !== 10'h000) begin
      miscompares++;
      $display("FAIL reset outputs: got %h/%b/%b want 00/0/0",
               ps2_data, ps2_data_clk, ps2_err);
    end
    reset = 1'b0;
    idle(20);
    clear_mon();
  endtask

  task automatic test_single();
    clear_mon();
    send_frame(8'h1C, odd_bit(8'h1C), 1'b1, 1'b0);
    expect_frames("single", 1, 8'h1C, 8'h00, 0);
    check_data("single", 8'h1C);
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'hF0, odd_bit(8'hF0), 1'b1, 1'b0);
    send_frame(8'h1C, odd_bit(8'h1C), 1'b1, 1'b0);
    expect_frames("b2b", 2, 8'hF0, 8'h1C, 0);
    idle(100);
    check_data("b2b_hold", 8'h1C);
  endtask

  task automatic test_bad_frames();
    clear_mon();
    send_frame(8'h5A, ~odd_bit(8'h5A), 1'b1, 1'b0);
    expect_frames("bad_parity", 0, 8'h00, 8'h00, 1);
    check_data("bad_parity", 8'h1C);
    clear_mon();
    send_frame(8'h5A, odd_bit(8'h5A), 1'b0, 1'b0);
    expect_frames("bad_stop", 0, 8'h00, 8'h00, 1);
    check_data("bad_stop", 8'h1C);
  endtask

  task automatic test_timeout();
    int dt;
    clear_mon();
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i), 1'b0);
    idle(TIMEOUT + 200);
    expect_frames("timeout", 0, 8'h00, 8'h00, 1);
    dt = last_err_cyc - last_fall_cyc;
    vectors++;
    if (dt < TIMEOUT || dt > TIMEOUT + 2 * FILTER + 10) begin
      miscompares++;
      $display("FAIL timeout delay: got %0d want %0d..%0d",
               dt, TIMEOUT, TIMEOUT + 2 * FILTER + 10);
    end
    clear_mon();
    send_frame(8'h5A, odd_bit(8'h5A), 1'b1, 1'b0);
    expect_frames("after_timeout", 1, 8'h5A, 8'h00, 0);
  endtask

  task automatic test_glitch();
    clear_mon();
    send_frame(8'h1C, odd_bit(8'h1C), 1'b1, 1'b1);
    expect_frames("glitch", 1, 8'h1C, 8'h00, 0);
  endtask

  task automatic test_reset_mid();
    int bad;
    clear_mon();
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock50);
      if (ps2_data !== 8'h00 || ps2_data_clk || ps2_err) bad++;
    end
    vectors++;
    if (bad != 0 || got_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid outputs: got %0d bad cycles, %0d strobes want 0",
               bad, got_q.size());
    end
    reset = 1'b0;
    idle(20);
    clear_mon();
    send_frame(8'h29, odd_bit(8'h29), 1'b1, 1'b0);
    expect_frames("reset_mid", 1, 8'h29, 8'h00, 0);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_err;
    logic [7:0] b;
    logic       p;
    logic       s;
    int         kind;
    clear_mon();
    exp_err = 0;
    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom);
      kind = $urandom_range(0, 5);
      p    = (kind == 0) ? ~odd_bit(b) : odd_bit(b);
      s    = (kind == 1) ? 1'b0 : 1'b1;
      send_frame(b, p, s, 1'($urandom_range(0, 1)));
      if (kind > 1) exp_q.push_back(b);
      else exp_err++;
    end
    idle(2 * FILTER + 10);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL random count: got %0d want %0d",
               got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL random byte%0d: got %h want %h",
                   i, got_q[i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (err_cnt != exp_err) begin
      miscompares++;
      $display("FAIL random errs: got %0d want %0d", err_cnt, exp_err);
    end
    vectors++;
    if (overlap_cnt != 0) begin
      miscompares++;
      $display("FAIL random overlap: got %0d want 0", overlap_cnt);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    reset       = 1'b1;
    ps2_clk     = 1'b1;
    ps2_dat     = 1'b1;
    clear_mon();
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_frames();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
